serial_adder: RTL and testbench

Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It instantiates a single `fa_using_ha` full-adder slice as its arithmetic element and adds a carry flip-flop, operand/result shift registers, a bit counter and a start/busy/done handshake. It sits directly around the full-adder stage and sequences operands into it. It is the area-minimal alternative to a WIDTH-wide ripple adder built from the same slice.

---
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one fa_using_ha slice plus carry flop, operand/result
// shift registers and a bit counter; adds a + b + cin LSB first.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module fa_using_ha (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s1),  .c_o(c1));
  half_adder u_ha1 (.a_i(s1),  .b_i(c_i), .s_o(s_o), .c_o(c2));

  assign c_o = c1 | c2;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] sumsh_q, sumsh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] msb_bit;

  fa_using_ha u_fa (
    .a_i(sha_q[0]),
    .b_i(shb_q[0]),
    .c_i(carry_q),
    .s_o(fa_s),
    .c_o(fa_c)
  );

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sumsh_d = sumsh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    msb_bit = '0;
    msb_bit[WIDTH-1] = fa_s;

    if (state_q == RUN) begin
      // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at LSB.
      sumsh_d = (sumsh_q >> 1) | msb_bit;
      sha_d   = sha_q >> 1;
      shb_d   = shb_q >> 1;
      carry_d = fa_c;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        sum_d   = sumsh_d;
        cout_d  = fa_c;
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
      if (start) begin
        sha_d   = a;
        shb_d   = b;
        carry_d = cin;
        cnt_d   = '0;
        sumsh_d = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      sumsh_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sumsh_q <= sumsh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for the directed
// scenarios and a 3-bit instance for an exhaustive sweep.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0] q8[$];
  logic [3:0] q3[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done8; reports cycles waited and busy cycles seen.
  task automatic wait_done8(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) busy_cyc++;
      tick();
      cyc++;
    end
    vectors++;
    if (done8 !== 1'b1) begin
      miscompares++;
      $display("FAIL done8_timeout: done=%b after %0d cycles, required 1", done8, cyc);
    end
    vectors++;
    if (busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_done_overlap: busy=%b in done cycle, required 0", busy8);
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string name);
    int cyc, bc;
    logic [8:0] exp;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    wait_done8(cyc, bc);
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("FAIL %s_latency: done after %0d cycles, required 8", name, cyc);
    end
    vectors++;
    if (bc !== 8) begin
      miscompares++;
      $display("FAIL %s_busy_len: busy high %0d cycles, required 8", name, bc);
    end
    exp = (q8.size() != 0) ? q8.pop_front() : 9'h1xx;
    vectors++;
    if ({cout8, sum8} !== exp) begin
      miscompares++;
      $display("FAIL %s_result: got {cout,sum}=%h, required %h", name, {cout8, sum8}, exp);
    end
    tick();
    vectors++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_pulse: done=%b busy=%b after done cycle, required 0 0", name, done8, busy8);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b1; start3 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    a3 = 3'h7; b3 = 3'h7; cin3 = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy8, done8, cout8, sum8} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset8: busy=%b done=%b cout=%b sum=%h, required all 0", busy8, done8, cout8, sum8);
    end
    vectors++;
    if ({busy3, done3, cout3, sum3} !== 6'h0) begin
      miscompares++;
      $display("FAIL reset3: busy=%b done=%b cout=%b sum=%h, required all 0", busy3, done3, cout3, sum3);
    end
    start8 = 1'b0; start3 = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    run_op8(8'h3C, 8'h5A, 1'b0, "add_3c_5a");
    run_op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
    run_op8(8'h00, 8'h00, 1'b0, "add_zero");
    run_op8(8'h00, 8'h00, 1'b1, "add_cin_only");
    run_op8(8'h80, 8'h80, 1'b0, "add_msb");
  endtask

  task automatic test_ignored_start;
    int cyc, bc, extra_done;
    logic [8:0] exp;
    q8.push_back(9'h030);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(cyc, bc);
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL ignored_start_latency: done %0d cycles after 2nd start, required 5", cyc);
    end
    exp = (q8.size() != 0) ? q8.pop_front() : 9'h1xx;
    vectors++;
    if ({cout8, sum8} !== exp) begin
      miscompares++;
      $display("FAIL ignored_start_result: got %h, required %h", {cout8, sum8}, exp);
    end
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) extra_done++;
    end
    vectors++;
    if (extra_done !== 0) begin
      miscompares++;
      $display("FAIL ignored_start_extra: %0d cycles with busy/done after result, required 0", extra_done);
    end
  endtask

  task automatic test_reset_abort;
    int seen_done;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy8, done8, cout8, sum8} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_abort_state: busy=%b done=%b cout=%b sum=%h, required all 0", busy8, done8, cout8, sum8);
    end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done !== 0 || sum8 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_abort_done: %0d done pulses, sum=%h, required 0 and 00", seen_done, sum8);
    end
    run_op8(8'hAA, 8'h55, 1'b1, "after_abort");
  endtask

  task automatic test_back_to_back;
    logic [7:0] av[4];
    logic [7:0] bv[4];
    logic       cv[4];
    int cyc, bc;
    logic [8:0] exp;
    av = '{8'h12, 8'hF0, 8'h7F, 8'hC3};
    bv = '{8'h34, 8'h0F, 8'h81, 8'hC3};
    cv = '{1'b0, 1'b1, 1'b0, 1'b1};
    a8 = av[0]; b8 = bv[0]; cin8 = cv[0]; start8 = 1'b1;
    q8.push_back({1'b0, av[0]} + {1'b0, bv[0]} + 9'(cv[0]));
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_done8(cyc, bc);
      vectors++;
      if (cyc !== 8) begin
        miscompares++;
        $display("FAIL b2b_period[%0d]: done %0d cycles after accept, required 8", i, cyc);
      end
      exp = (q8.size() != 0) ? q8.pop_front() : 9'h1xx;
      vectors++;
      if ({cout8, sum8} !== exp) begin
        miscompares++;
        $display("FAIL b2b_result[%0d]: got %h, required %h", i, {cout8, sum8}, exp);
      end
      if (i < 3) begin
        a8 = av[i+1]; b8 = bv[i+1]; cin8 = cv[i+1];
        q8.push_back({1'b0, av[i+1]} + {1'b0, bv[i+1]} + 9'(cv[i+1]));
      end else begin
        start8 = 1'b0;
      end
      tick();
      vectors++;
      if (busy8 !== (i < 3) || done8 !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_restart[%0d]: busy=%b done=%b, required %b 0", i, busy8, done8, i < 3);
      end
    end
  endtask

  task automatic test_w3_sweep;
    logic [2:0] ta, tb;
    logic       tc;
    logic [3:0] exp;
    int cyc;
    for (int i = 0; i < 128; i++) begin
      {ta, tb, tc} = 7'(i);
      q3.push_back({1'b0, ta} + {1'b0, tb} + 4'(tc));
      a3 = ta; b3 = tb; cin3 = tc; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      a3 = ~ta; b3 = ~tb; cin3 = ~tc;
      cyc = 0;
      while (done3 !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      exp = (q3.size() != 0) ? q3.pop_front() : 4'hx;
      vectors++;
      if (done3 !== 1'b1 || cyc !== 3 || {cout3, sum3} !== exp) begin
        miscompares++;
        $display("FAIL w3_sweep a=%0d b=%0d cin=%0d: done=%b after %0d cycles got %h, required done after 3 with %h",
                 ta, tb, tc, done3, cyc, {cout3, sum3}, exp);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    test_reset();
    test_basic();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_w3_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
